// File: rtl/lsu_if.sv
// lsu_if: request, response and data-memory port signals of the load/store sequencer
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_valid, mem_we, mem_addr, mem_be, mem_wdata
    );
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_valid, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer with misaligned split, lane alignment and load extension
module lsu_ctrl #(
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input logic  clk,
    input logic  rst,
    lsu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t      state, next;
    logic        we, err;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, buf_lo, buf_hi;
    logic [1:0]  off;
    logic [3:0]  mask;
    logic [7:0]  bm;
    logic [31:0] masked, merged, ext, base;
    logic [63:0] wide;
    logic        in_mis, in_err;

    function automatic logic [2:0] sz(input logic [1:0] f);
        return f == 2'b00 ? 3'd1 : f == 2'b01 ? 3'd2 : 3'd4;
    endfunction

    always_comb begin
        in_mis = ({1'b0, bus.req_addr[1:0]} + sz(bus.req_funct3[1:0])) > 3'd4;
        in_err = bus.req_funct3 == 3'b011 || bus.req_funct3[2:1] == 2'b11 ||
                 (bus.req_we && bus.req_funct3[2]) || (!SPLIT_MISALIGNED && in_mis);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we     <= 1'b0;
            err    <= 1'b0;
            f3     <= 3'b0;
            addr   <= 32'b0;
            wdata  <= 32'b0;
            buf_lo <= 32'b0;
            buf_hi <= 32'b0;
        end else begin
            if (state == IDLE && bus.req_valid) begin
                we    <= bus.req_we;
                err   <= in_err;
                f3    <= bus.req_funct3;
                addr  <= bus.req_addr;
                wdata <= bus.req_wdata;
            end
            if (state == ACC0 && bus.mem_ready && !we) buf_lo <= bus.mem_rdata;
            if (state == ACC1 && bus.mem_ready && !we) buf_hi <= bus.mem_rdata;
        end
    end

    always_comb begin
        next = state;
        case (state)
            IDLE: next = bus.req_valid ? (in_err ? RESP : ACC0) : IDLE;
            ACC0: next = bus.mem_ready ? (|bm[7:4] ? ACC1 : RESP) : ACC0;
            ACC1: next = bus.mem_ready ? RESP : ACC1;
            RESP: next = bus.resp_ready ? IDLE : RESP;
            default: next = IDLE;
        endcase
    end

    // Lane alignment for stores and right-justification of load data share the byte offset
    always_comb begin
        off    = addr[1:0];
        base   = {addr[31:2], 2'b00};
        mask   = f3[1:0] == 2'b00 ? 4'b0001 : f3[1:0] == 2'b01 ? 4'b0011 : 4'b1111;
        bm     = {4'b0, mask} << off;
        masked = f3[1:0] == 2'b00 ? {24'b0, wdata[7:0]} : f3[1:0] == 2'b01 ? {16'b0, wdata[15:0]} : wdata;
        wide   = {32'b0, masked} << {off, 3'b000};
        merged = 32'({buf_hi, buf_lo} >> {off, 3'b000});
        ext    = f3 == 3'b000 ? {{24{merged[7]}}, merged[7:0]} :
                 f3 == 3'b001 ? {{16{merged[15]}}, merged[15:0]} :
                 f3 == 3'b100 ? {24'b0, merged[7:0]} :
                 f3 == 3'b101 ? {16'b0, merged[15:0]} : merged;
    end

    always_comb begin
        bus.req_ready  = state == IDLE;
        bus.mem_valid  = state == ACC0 || state == ACC1;
        bus.mem_we     = bus.mem_valid && we;
        bus.mem_addr   = state == ACC0 ? base : state == ACC1 ? base + 32'd4 : 32'b0;
        bus.mem_be     = state == ACC0 ? bm[3:0] : state == ACC1 ? bm[7:4] : 4'b0;
        bus.mem_wdata  = state == ACC0 ? wide[31:0] : state == ACC1 ? wide[63:32] : 32'b0;
        bus.resp_valid = state == RESP;
        bus.resp_err   = state == RESP && err;
        bus.resp_rdata = (state == RESP && !we && !err) ? ext : 32'b0;
    end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store sequencer between the pipeline MEM stage and the data-memory port.
- Accepts one load/store request at a time and drives byte-enables and lane-aligned write data.
- Splits misaligned accesses into two word accesses; merges, shifts and sign/zero-extends load data.
- Returns the result through a valid/ready response handshake.

Parameters:
- SPLIT_MISALIGNED, 1: 1 = split misaligned accesses into two word accesses; 0 = report misaligned as error, no memory access.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- resp_valid  output  1  response present
- resp_ready  input  1  consumer accepts response
- resp_rdata  output  32  extended load data; 0 for stores/errors
- resp_err  output  1  illegal funct3 or unsupported misalignment
- mem_valid  output  1  memory access request
- mem_ready  input  1  memory accepts; for reads mem_rdata is valid this cycle
- mem_we  output  1  write strobe
- mem_addr  output  32  word-aligned address, bits[1:0] = 0
- mem_be  output  4  byte enables
- mem_wdata  output  32  lane-aligned write data
- mem_rdata  input  32  read data

Behaviour:
- Reset (async, immediate): state IDLE. req_ready=1 after reset release; all other outputs 0. An in-flight access is abandoned and mem_valid drops combinationally with rst.
- States: IDLE, ACC0, ACC1, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid capture we, funct3, addr, wdata.
  - Illegal funct3 (011, 110, 111, or store with 1xx) -> RESP with err=1.
  - Misaligned with SPLIT_MISALIGNED=0 -> RESP with err=1.
  - Otherwise -> ACC0.
- Size and offset: size = 1/2/4 from funct3[1:0]; off = addr[1:0]. Misaligned when off+size > 4.
- Store data: lane vector wide = {32'b0, size-masked wdata} << 8*off (64 bits). Byte mask bm = ((1<<size)-1) << off (8 bits).
- ACC0:
  - mem_valid=1, mem_addr={addr[31:2],2'b00}, mem_be=bm[3:0], mem_wdata=wide[31:0], mem_we=we.
  - All outputs are held stable until mem_ready.
  - On mem_ready a load captures mem_rdata into buf_lo.
  - Next state: ACC1 if bm[7:4]!=0, else RESP.
- ACC1:
  - mem_addr = {addr[31:2],2'b00} + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
  - mem_be=bm[7:4], mem_wdata=wide[63:32].
  - On mem_ready a load captures buf_hi. Next state RESP.
- RESP:
  - resp_valid=1.
  - Load result: merged = {buf_hi,buf_lo} >> 8*off, then extend per funct3: 000 sign from bit 7, 001 sign from bit 15, 100/101 zero, 010 pass-through.
  - resp_rdata and resp_err are registered and stable while resp_valid=1.
  - On resp_ready -> IDLE. No new request is accepted in the same cycle (req_ready=0 outside IDLE).
- Latency (mem_ready always 1): request accepted at cycle N, mem_valid at N+1, resp_valid at N+2. A split access adds one cycle. An error response appears at N+1 with no mem_valid.
- Stall rules:
  - mem_ready held low: stay in ACC0/ACC1 indefinitely with the request unchanged.
  - resp_ready low: hold RESP.
  - No second memory access is issued before the first is accepted.

Test Plan:
- Aligned LW: addr 0x100, mem_rdata 0xDEADBEEF, mem_ready=1 -> one access, mem_be 1111, addr 0x100, resp_rdata 0xDEADBEEF at N+2.
- LB/LBU: addr 0x203, mem_rdata 0x80123456 -> mem_be 1000. LB gives 0xFFFFFF80; LBU gives 0x00000080.
- Misaligned LW, SPLIT=1: addr 0x102.
  - Access 1: 0x100, be 1100, data 0xAAAA1111.
  - Access 2: 0x104, be 0011, data 0x2222BBBB.
  - Result: resp_rdata 0xBBBBAAAA.
- Misaligned SH: addr 0xFFFFFFFF, wdata 0x0000CDEF.
  - Access 1: 0xFFFFFFFC, be 1000, wdata 0xEF000000.
  - Access 2: 0x00000000, be 0001, wdata 0x000000CD.
  - resp_err=0.
- Errors and backpressure:
  - funct3 011 -> resp_err=1, no mem_valid.
  - SPLIT=0 with LH at 0x3 -> resp_err=1, no mem_valid.
  - mem_ready low 5 cycles -> mem_addr/be/wdata stable throughout.
  - resp_ready low 3 cycles -> resp held and req_ready=0.
- Reset mid-access: assert rst while in ACC1 with mem_ready=0 -> mem_valid=0 immediately. After release: IDLE, req_ready=1, a new LW completes normally.
